// File: rtl/async_fifo.sv
// Elastic buffer keeping the Gray-pointer crossing structure of a dual-clock FIFO, on a single clock.
// Latency: read data registered, valid right after the accepting edge; a write is readable 4 edges later.
// Backpressure: p_write_full / p_read_empty gate requests and lag by up to 3 cycles when they deassert.
//
// Ports:
//   clk           single clock, all logic on the rising edge
//   rstn          synchronous active-low reset
//   p_write_en    write request, accepted when !p_write_full
//   p_write_data  entry to write
//   p_write_full  registered full flag
//   p_read_en     read request, accepted when !p_read_empty
//   p_read_data   registered read data, holds while no read is accepted
//   p_read_empty  registered empty flag

module async_fifo #(
  parameter int BITS = 32,
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            p_write_en,
  input  logic [BITS-1:0] p_write_data,
  output logic            p_write_full,
  input  logic            p_read_en,
  output logic [BITS-1:0] p_read_data,
  output logic            p_read_empty
);

  localparam int AW = $clog2(SIZE);
  localparam int PW = AW + 1;

  // Gray code of a pointer exactly SIZE ahead: the top two bits flip.
  localparam logic [PW-1:0] TOP2 = PW'(3) << (PW - 2);

  if (SIZE < 2 || (SIZE & (SIZE - 1)) != 0) begin : g_bad_size
    $error("async_fifo: SIZE must be a power of two and at least 2");
  end

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // storage
  logic [BITS-1:0] mem_q [SIZE];

  // write side
  logic [PW-1:0] wptr_q,  wptr_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] rq1_q,   rq1_d;
  logic [PW-1:0] rq2_q,   rq2_d;
  logic          full_q,  full_d;

  // read side
  logic [PW-1:0]   rptr_q,  rptr_d;
  logic [PW-1:0]   rgray_q, rgray_d;
  logic [PW-1:0]   wq1_q,   wq1_d;
  logic [PW-1:0]   wq2_q,   wq2_d;
  logic            empty_q, empty_d;
  logic [BITS-1:0] rdata_q, rdata_d;

  logic wr_acc;
  logic rd_acc;

  always_comb begin
    wr_acc  = p_write_en && !full_q;
    rd_acc  = p_read_en && !empty_q;

    wptr_d  = wptr_q + {{AW{1'b0}}, wr_acc};
    wgray_d = bin2gray(wptr_d);
    rptr_d  = rptr_q + {{AW{1'b0}}, rd_acc};
    rgray_d = bin2gray(rptr_d);

    // two-flop pointer exchange in each direction
    wq1_d   = wgray_q;
    wq2_d   = wq1_q;
    rq1_d   = rgray_q;
    rq2_d   = rq1_q;

    // Flags look at the post-update local pointer against the stale synchronized
    // remote pointer, so they assert immediately and release late.
    full_d  = (wgray_d == (rq2_q ^ TOP2));
    empty_d = (rgray_d == wq2_q);

    rdata_d = rdata_q;
    if (rd_acc) begin
      rdata_d = mem_q[rptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
      full_q  <= 1'b0;
      rptr_q  <= '0;
      rgray_q <= '0;
      wq1_q   <= '0;
      wq2_q   <= '0;
      empty_q <= 1'b1;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      wgray_q <= wgray_d;
      rq1_q   <= rq1_d;
      rq2_q   <= rq2_d;
      full_q  <= full_d;
      rptr_q  <= rptr_d;
      rgray_q <= rgray_d;
      wq1_q   <= wq1_d;
      wq2_q   <= wq2_d;
      empty_q <= empty_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rstn && wr_acc) begin
      mem_q[wptr_q[AW-1:0]] <= p_write_data;
    end
  end

  assign p_write_full = full_q;
  assign p_read_empty = empty_q;
  assign p_read_data  = rdata_q;

  // Structural invariants of the pointer exchange.
  a_wgray_step: assert property (@(posedge clk) disable iff (!rstn)
    $past(rstn) |-> ($countones(wgray_q ^ $past(wgray_q)) <= 1));
  a_rgray_step: assert property (@(posedge clk) disable iff (!rstn)
    $past(rstn) |-> ($countones(rgray_q ^ $past(rgray_q)) <= 1));
  a_occupancy:  assert property (@(posedge clk) disable iff (!rstn)
    (wptr_q - rptr_q) <= PW'(SIZE));
  a_full_safe:  assert property (@(posedge clk) disable iff (!rstn)
    ((wptr_q - rptr_q) == PW'(SIZE)) |-> full_q);
  a_empty_safe: assert property (@(posedge clk) disable iff (!rstn)
    (wptr_q == rptr_q) |-> empty_q);

endmodule

// File: tb/tb_async_fifo.sv
module tb_async_fifo;

  localparam int BITS = 32;
  localparam int SIZE = 16;

  logic            clk = 1'b0;
  logic            rstn;
  logic            we;
  logic [BITS-1:0] wd;
  logic            full;
  logic            re;
  logic [BITS-1:0] rd;
  logic            empty;

  always #5 clk = ~clk;

  async_fifo #(.BITS(BITS), .SIZE(SIZE)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .p_write_en   (we),
    .p_write_data (wd),
    .p_write_full (full),
    .p_read_en    (re),
    .p_read_data  (rd),
    .p_read_empty (empty)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: content queue plus running write/read totals. A write
  // becomes visible to the read side 3 edges later and a read frees space for
  // the write side 3 edges later, so the flags follow from totals history.
  logic [BITS-1:0] q[$];
  logic [BITS-1:0] got_q[$];
  int              wr_tot, rd_tot;
  int              wh[4];
  int              rh[4];
  logic            exp_full, exp_empty;
  logic [BITS-1:0] exp_data;
  logic            last_racc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic step(input logic r_n, input logic w_en, input logic [BITS-1:0] w_dat,
                      input logic r_en);
    bit w_acc, r_acc;
    rstn = r_n;
    we   = w_en;
    wd   = w_dat;
    re   = r_en;
    @(posedge clk);
    if (!r_n) begin
      q.delete();
      wr_tot    = 0;
      rd_tot    = 0;
      for (int i = 0; i < 4; i++) begin
        wh[i] = 0;
        rh[i] = 0;
      end
      exp_full  = 1'b0;
      exp_empty = 1'b1;
      exp_data  = '0;
      last_racc = 1'b0;
    end else begin
      w_acc = w_en && !exp_full;
      r_acc = r_en && !exp_empty;
      if (r_acc && q.size() > 0) exp_data = q.pop_front();
      if (w_acc) q.push_back(w_dat);
      wr_tot += int'(w_acc);
      rd_tot += int'(r_acc);
      for (int i = 3; i > 0; i--) begin
        wh[i] = wh[i-1];
        rh[i] = rh[i-1];
      end
      wh[0] = wr_tot;
      rh[0] = rd_tot;
      exp_empty = (rd_tot == wh[3]);
      exp_full  = ((wh[0] - rh[3]) == SIZE);
      last_racc = r_acc;
    end
    #1;
    chk("empty", 32'(empty), 32'(exp_empty));
    chk("full",  32'(full),  32'(exp_full));
    chk("rdata", rd, exp_data);
    if (last_racc) got_q.push_back(rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BITS-1:0] words[100];
    int              sent;
    int              cyc;
    bit              w_en, r_en;

    rstn = 1'b0;
    we   = 1'b0;
    re   = 1'b0;
    wd   = '0;

    // reset held with both requests active
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, $urandom, 1'b1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_data",  rd,         32'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b1);
    chk("rst_nothing_stored", 32'(empty), 32'd1);

    // smoke
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 32'(i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b0);
    got_q.delete();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, '0, 1'b1);
    chk("smoke_cnt", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) chk("smoke_data", got_at(i), 32'(i));
    chk("smoke_empty", 32'(empty), 32'd1);

    // full and overflow
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 32'(100 + i), 1'b0);
      if (i == 15) chk("ovf_full16", 32'(full), 32'd1);
    end
    got_q.delete();
    for (int i = 0; i < 24; i++) step(1'b1, 1'b0, '0, 1'b1);
    chk("ovf_cnt", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) chk("ovf_data", got_at(i), 32'(100 + i));
    chk("ovf_empty", 32'(empty), 32'd1);

    // underflow
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b1);
    chk("uf_hold", rd, 32'd115);
    step(1'b1, 1'b1, 32'h0000_00A5, 1'b0);
    got_q.delete();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b1);
    chk("uf_cnt",  32'(got_q.size()), 32'd1);
    chk("uf_data", got_at(0), 32'h0000_00A5);

    // interleaved random traffic with wrap-around
    for (int i = 0; i < 100; i++) words[i] = $urandom;
    got_q.delete();
    sent = 0;
    cyc  = 0;
    while (got_q.size() < 100 && cyc < 3000) begin
      w_en = (sent < 100) && !exp_full && ($urandom_range(0, 1) == 1);
      r_en = ($urandom_range(0, 1) == 1);
      step(1'b1, w_en, words[(sent < 100) ? sent : 0], r_en);
      if (w_en) sent++;
      cyc++;
    end
    chk("rand_cnt", 32'(got_q.size()), 32'd100);
    for (int i = 0; i < 100; i++) chk("rand_data", got_at(i), words[i]);

    // mid-operation reset
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, $urandom, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("mr_empty", 32'(empty), 32'd1);
    chk("mr_data",  rd,         32'd0);
    step(1'b1, 1'b1, 32'h1, 1'b0);
    got_q.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1);
    chk("mr_cnt",  32'(got_q.size()), 32'd1);
    chk("mr_data", got_at(0), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
